tap_ctrl_param: RTL and testbench
=================================

TAP_CTRL_PARAM -- requirements
Module: tap_ctrl_param

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width; legal range 2..8.
REQ-002 Parameter DR_WIDTH, default 8: user data register width; legal range 1..32.
REQ-003 Parameter IDCODE_VAL, default 32'h1234_5001: 32-bit device ID; bit 0 SHALL be 1.
REQ-004 GCLK_Pad  input  1  system clock; all state changes on the rising edge.
REQ-005 TRST_Pad  input  1  reset; synchronous, active-high.
REQ-006 TMS_Pad  input  1  test mode select, sampled on each GCLK_Pad rising edge.
REQ-007 TDI_Pad  input  1  serial data in, sampled on each GCLK_Pad rising edge.
REQ-008 TDO_Pad  output  1  serial data out, registered.
REQ-009 TDO_en  output  1  high while the FSM is in Shift-DR or Shift-IR, registered.
REQ-010 state_obs_Pad  output  4  current FSM state code, registered.
REQ-011 ir_out  output  IR_WIDTH  active instruction.
REQ-012 user_dr_out  output  DR_WIDTH  last updated USER register contents.
REQ-013 user_update  output  1  one-cycle pulse in the cycle after Update-DR, when the USER instruction is active.

Function
REQ-014 The FSM SHALL implement the 16 IEEE 1149.1 states, with state_obs_Pad codes as follows:
- TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-015 Transitions SHALL follow IEEE 1149.1, listed as TMS=0 / TMS=1:
- TLR: RTI / TLR
- RTI: RTI / SelDR
- SelDR: CapDR / SelIR
- SelIR: CapIR / TLR
- Cap: Sh / Ex1
- Sh: Sh / Ex1
- Ex1: Pau / Upd
- Pau: Pau / Ex2
- Ex2: Sh / Upd
- Upd: RTI / SelDR
REQ-016 Five consecutive cycles with TMS_Pad=1 SHALL reach TLR from any state.
REQ-017 Instruction decode:
- IDCODE = 1
- USER = 2
- BYPASS = all-ones
- any other code selects BYPASS.
REQ-018 CapIR SHALL load the IR shift register with binary ...01 (LSB=1, bit1=0, upper bits 0).
REQ-019 ShIR and ShDR SHALL shift right one bit per cycle; TDI_Pad enters the MSB, and the LSB is shifted out to TDO_Pad.
REQ-020 UpdIR SHALL copy the IR shift register to ir_out.
REQ-021 CapDR SHALL load the register selected by ir_out:
- IDCODE: IDCODE_VAL
- USER: user_dr_out
- BYPASS: 1'b0 into the single-bit bypass register.
REQ-022 UpdDR with USER active SHALL copy the DR shift register to user_dr_out and pulse user_update for exactly one cycle; UpdDR with any other instruction SHALL have no effect.
REQ-023 TDO_Pad SHALL present the bit shifted out in the previous rising edge; it SHALL be 0 whenever TDO_en is 0.
REQ-024 Entering TLR through TMS (not reset) SHALL set ir_out to IDCODE; user_dr_out SHALL be retained.
REQ-025 Pause states SHALL hold all shift registers unchanged; resuming via Ex2->Sh SHALL continue the shift without loss or duplication of bits.
REQ-026 The IDCODE register SHALL shift 32 bits before TDI data appears on TDO_Pad; the BYPASS path SHALL delay TDI by exactly one bit.

Reset
REQ-027 TRST_Pad=1 at a rising edge SHALL force the following regardless of TMS_Pad or current state:
- state TLR
- state_obs_Pad=F
- ir_out=IDCODE
- user_dr_out=0
- TDO_Pad=0, TDO_en=0, user_update=0
- all shift registers cleared.
REQ-028 Reset asserted mid-shift SHALL abort the shift, leaving no partial update of ir_out or user_dr_out.
REQ-029 Reset SHALL take priority over an Update state occurring in the same cycle.

Verification
REQ-030 Scenario: TRST_Pad=1 for one cycle, then TMS=0 for one cycle -> state_obs_Pad=F, then C; ir_out=1.
REQ-031 Scenario: from RTI, TMS sequence 1,0,0 then 32 shift cycles with TMS=0, TDI=0 -> TDO_Pad stream LSB-first equals 32'h1234_5001.
REQ-032 Scenario: load IR=2 (USER), shift DR 8'hA5 then Update-DR -> user_dr_out=A5 and user_update high for exactly one cycle; a second DR scan captures A5 on TDO_Pad.
REQ-033 Scenario: IR=4'hF (BYPASS), shift TDI pattern 1,0,1,1 -> TDO_Pad shows 0,1,0,1 (the captured 0 first, then TDI delayed by one bit).
REQ-034 Scenario: from ShDR, TMS=1 for 5 cycles -> the state sequence Ex1DR, UpdDR, SelDR, SelIR, TLR appears on state_obs_Pad as 1,5,7,4,F.
REQ-035 Scenario: TRST_Pad=1 during ShIR after 2 of 4 bits -> state_obs_Pad=F and ir_out=1; no UpdIR effect is observed.

Source files
------------

// File: rtl/tap_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tap_ctrl_param
// Brief    : IEEE 1149.1 TAP controller with IDCODE, USER and BYPASS paths.
// Revision : 1.0
// ============================================================================
module tap_ctrl_param #(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
    input  logic                GCLK_Pad,
    input  logic                TRST_Pad,
    input  logic                TMS_Pad,
    input  logic                TDI_Pad,
    output logic                TDO_Pad,
    output logic                TDO_en,
    output logic [3:0]          state_obs_Pad,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [DR_WIDTH-1:0] user_dr_out,
    output logic                user_update
);

    typedef enum logic [3:0] {
        S_EX2_DR = 4'h0, S_EX1_DR = 4'h1, S_SH_DR  = 4'h2, S_PAU_DR = 4'h3,
        S_SEL_IR = 4'h4, S_UPD_DR = 4'h5, S_CAP_DR = 4'h6, S_SEL_DR = 4'h7,
        S_EX2_IR = 4'h8, S_EX1_IR = 4'h9, S_SH_IR  = 4'hA, S_PAU_IR = 4'hB,
        S_RTI    = 4'hC, S_UPD_IR = 4'hD, S_CAP_IR = 4'hE, S_TLR    = 4'hF
    } state_t;

    localparam logic [IR_WIDTH-1:0] c_ir_idcode  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] c_ir_user    = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(1);

    state_t                r_state;
    state_t                w_next;
    logic [IR_WIDTH-1:0]   r_ir_sr;
    logic [IR_WIDTH-1:0]   r_ir;
    logic [31:0]           r_id_sr;
    logic [DR_WIDTH-1:0]   r_user_sr;
    logic [DR_WIDTH-1:0]   r_user;
    logic                  r_byp;
    logic                  r_tdo;
    logic                  r_tdo_en;
    logic                  r_upd;
    logic [DR_WIDTH-1:0]   w_user_shifted;
    logic                  w_sel_id;
    logic                  w_sel_user;
    logic                  w_shifting;
    logic                  w_tdo_bit;

    assign w_sel_id   = (r_ir == c_ir_idcode);
    assign w_sel_user = (r_ir == c_ir_user);
    assign w_shifting = (r_state == S_SH_DR) || (r_state == S_SH_IR);

    generate
        if (DR_WIDTH == 1) begin : g_user_sr_bit
            assign w_user_shifted = TDI_Pad;
        end else begin : g_user_sr_vec
            assign w_user_shifted = {TDI_Pad, r_user_sr[DR_WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:    w_next = TMS_Pad ? S_TLR    : S_RTI;
            S_RTI:    w_next = TMS_Pad ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next = TMS_Pad ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next = TMS_Pad ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next = TMS_Pad ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next = TMS_Pad ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_next = TMS_Pad ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_next = TMS_Pad ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next = TMS_Pad ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next = TMS_Pad ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next = TMS_Pad ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next = TMS_Pad ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next = TMS_Pad ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_next = TMS_Pad ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_next = TMS_Pad ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next = TMS_Pad ? S_SEL_DR : S_RTI;
            default:  w_next = S_TLR;
        endcase
    end

    // Bit leaving the active shift path on this edge.
    always_comb begin
        w_tdo_bit = 1'b0;
        if (r_state == S_SH_IR)
            w_tdo_bit = r_ir_sr[0];
        else if (w_sel_id)
            w_tdo_bit = r_id_sr[0];
        else if (w_sel_user)
            w_tdo_bit = r_user_sr[0];
        else
            w_tdo_bit = r_byp;
    end

    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad) begin
            r_state   <= S_TLR;
            r_ir_sr   <= '0;
            r_ir      <= c_ir_idcode;
            r_id_sr   <= '0;
            r_user_sr <= '0;
            r_user    <= '0;
            r_byp     <= 1'b0;
            r_tdo     <= 1'b0;
            r_tdo_en  <= 1'b0;
            r_upd     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_upd    <= 1'b0;
            r_tdo_en <= w_shifting;
            r_tdo    <= w_shifting ? w_tdo_bit : 1'b0;
            case (r_state)
                S_CAP_IR: r_ir_sr <= c_ir_capture;
                S_SH_IR:  r_ir_sr <= {TDI_Pad, r_ir_sr[IR_WIDTH-1:1]};
                S_UPD_IR: r_ir    <= r_ir_sr;
                S_CAP_DR: begin
                    if (w_sel_id)
                        r_id_sr <= IDCODE_VAL;
                    else if (w_sel_user)
                        r_user_sr <= r_user;
                    else
                        r_byp <= 1'b0;
                end
                S_SH_DR: begin
                    if (w_sel_id)
                        r_id_sr <= {TDI_Pad, r_id_sr[31:1]};
                    else if (w_sel_user)
                        r_user_sr <= w_user_shifted;
                    else
                        r_byp <= TDI_Pad;
                end
                S_UPD_DR: begin
                    if (w_sel_user) begin
                        r_user <= r_user_sr;
                        r_upd  <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Test-Logic-Reset reached via TMS restores IDCODE but keeps USER data.
            if (w_next == S_TLR)
                r_ir <= c_ir_idcode;
        end
    end

    assign TDO_Pad       = r_tdo;
    assign TDO_en        = r_tdo_en;
    assign state_obs_Pad = r_state;
    assign ir_out        = r_ir;
    assign user_dr_out   = r_user;
    assign user_update   = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_tap_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_ctrl_param
// Brief    : Directed self-checking bench for tap_ctrl_param (default params).
// Revision : 1.0
// ============================================================================
module tb_tap_ctrl_param;

    logic       clk = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] state_obs;
    logic [3:0] ir_out;
    logic [7:0] user_dr_out;
    logic       user_update;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] word;
    logic [7:0]  pat_in;
    logic [7:0]  pat_out;
    logic [3:0]  nib;

    tap_ctrl_param dut (
        .GCLK_Pad      (clk),
        .TRST_Pad      (trst),
        .TMS_Pad       (tms),
        .TDI_Pad       (tdi),
        .TDO_Pad       (tdo),
        .TDO_en        (tdo_en),
        .state_obs_Pad (state_obs),
        .ir_out        (ir_out),
        .user_dr_out   (user_dr_out),
        .user_update   (user_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        @(posedge clk);
        #1;
    endtask

    // From RTI: scan a 4-bit instruction and return to RTI.
    task automatic load_ir(input logic [3:0] v);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i]);
            if (i == 0) check("ir_capture_lsb", 32'(tdo), 32'h1);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        @(posedge clk);
        #1;
        check("rst_state", 32'(state_obs), 32'hF);
        check("rst_ir", 32'(ir_out), 32'h1);
        check("rst_user", 32'(user_dr_out), 32'h0);
        check("rst_tdo", 32'(tdo), 32'h0);
        check("rst_tdo_en", 32'(tdo_en), 32'h0);
        check("rst_upd", 32'(user_update), 32'h0);
        trst = 1'b0;
        step(1'b0, 1'b0);
        check("tlr_to_rti", 32'(state_obs), 32'hC);
        check("rti_ir", 32'(ir_out), 32'h1);

        // IDCODE scan
        step(1'b1, 1'b0);
        check("sel_dr", 32'(state_obs), 32'h7);
        step(1'b0, 1'b0);
        check("cap_dr", 32'(state_obs), 32'h6);
        step(1'b0, 1'b0);
        check("sh_dr", 32'(state_obs), 32'h2);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0);
            word[i] = tdo;
        end
        check("idcode_stream", word, 32'h1234_5001);
        check("idcode_tdo_en", 32'(tdo_en), 32'h1);

        // TMS=1 x5 from Shift-DR
        step(1'b1, 1'b0);
        check("exit_ex1dr", 32'(state_obs), 32'h1);
        step(1'b1, 1'b0);
        check("exit_upddr", 32'(state_obs), 32'h5);
        check("exit_en_low", 32'(tdo_en), 32'h0);
        step(1'b1, 1'b0);
        check("exit_seldr", 32'(state_obs), 32'h7);
        check("idcode_no_upd", 32'(user_update), 32'h0);
        step(1'b1, 1'b0);
        check("exit_selir", 32'(state_obs), 32'h4);
        step(1'b1, 1'b0);
        check("exit_tlr", 32'(state_obs), 32'hF);

        // USER load A5
        step(1'b0, 1'b0);
        load_ir(4'h2);
        check("ir_user", 32'(ir_out), 32'h2);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        pat_in = 8'hA5;
        for (int i = 0; i < 8; i++) step(i == 7, pat_in[i]);
        step(1'b1, 1'b0);
        check("upd_dr_state", 32'(state_obs), 32'h5);
        check("upd_not_yet", 32'(user_dr_out), 32'h0);
        step(1'b0, 1'b0);
        check("user_a5", 32'(user_dr_out), 32'hA5);
        check("user_pulse", 32'(user_update), 32'h1);
        step(1'b0, 1'b0);
        check("user_pulse_end", 32'(user_update), 32'h0);

        // Capture A5 back, with a pause mid-shift, while shifting in 3C
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        pat_in  = 8'h3C;
        pat_out = '0;
        for (int i = 0; i < 3; i++) begin
            step(i == 2, pat_in[i]);
            pat_out[i] = tdo;
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("pause_state", 32'(state_obs), 32'h3);
        check("pause_tdo", 32'(tdo), 32'h0);
        step(1'b1, 1'b0);
        check("ex2_state", 32'(state_obs), 32'h0);
        step(1'b0, 1'b0);
        for (int i = 3; i < 8; i++) begin
            step(i == 7, pat_in[i]);
            pat_out[i] = tdo;
        end
        check("user_readback", 32'(pat_out), 32'hA5);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("user_3c", 32'(user_dr_out), 32'h3C);
        check("user_pulse2", 32'(user_update), 32'h1);

        // BYPASS
        load_ir(4'hF);
        check("ir_bypass", 32'(ir_out), 32'hF);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        pat_in = 8'b0000_1101;
        nib = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, pat_in[i]);
            nib[i] = tdo;
        end
        check("bypass_stream", 32'(nib), 32'hA);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tms_tlr_state", 32'(state_obs), 32'hF);
        check("tms_tlr_ir", 32'(ir_out), 32'h1);
        check("tms_tlr_user_kept", 32'(user_dr_out), 32'h3C);

        // Reset during Shift-IR after 2 bits
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("sh_ir_state", 32'(state_obs), 32'hA);
        trst = 1'b1;
        step(1'b0, 1'b0);
        check("abort_state", 32'(state_obs), 32'hF);
        check("abort_ir", 32'(ir_out), 32'h1);
        check("abort_tdo_en", 32'(tdo_en), 32'h0);
        check("abort_user", 32'(user_dr_out), 32'h0);
        trst = 1'b0;
        step(1'b0, 1'b0);
        check("abort_ir_after", 32'(ir_out), 32'h1);

        // Reset coinciding with Update-DR
        load_ir(4'h2);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(i == 7, 1'b1);
        step(1'b1, 1'b0);
        check("pre_rst_upd", 32'(state_obs), 32'h5);
        trst = 1'b1;
        step(1'b0, 1'b0);
        check("rst_upd_state", 32'(state_obs), 32'hF);
        check("rst_upd_user", 32'(user_dr_out), 32'h0);
        check("rst_upd_pulse", 32'(user_update), 32'h0);
        trst = 1'b0;
        step(1'b1, 1'b0);
        check("rst_upd_pulse2", 32'(user_update), 32'h0);
        check("rst_upd_ir", 32'(ir_out), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
